// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling, framing error and break handling
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  output logic                 o_frame_error,
  output logic                 o_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST    = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rx_s;

  assign w_rx_s = r_sync[1];
  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_sync        <= 2'b11;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      o_data        <= '0;
      o_data_valid  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      r_sync        <= {r_sync[0], i_rx};
      o_data_valid  <= 1'b0;
      o_frame_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          // Re-check the line half a bit in to reject short glitches.
          if (r_cnt == C_HALF_M1) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_idx == I_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              o_data       <= r_shift;
              o_data_valid <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              o_frame_error <= 1'b1;
              r_state       <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line must return high before another start is accepted.
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver with randomized frames
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int NB   = 8;
  localparam int LAT  = CPB / 2 + (NB + 1) * CPB + 3;

  logic          clk;
  logic          i_reset;
  logic          i_rx;
  logic [NB-1:0] o_data;
  logic          o_data_valid;
  logic          o_frame_error;
  logic          o_busy;

  uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_frame_error(o_frame_error),
    .o_busy       (o_busy)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int          t0;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [7:0] last_good = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests = tests + 1;
    if (act != req) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the receiver presents a pulse.
  always @(negedge clk) begin
    if (!i_reset && (o_data_valid || o_frame_error)) begin
      exp_t e;
      check("valid_and_error_exclusive", int'(o_data_valid && o_frame_error), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_is_error", int'(o_frame_error), int'(e.is_err));
        if (o_data_valid && !e.is_err) begin
          check("rx_data", int'(o_data), int'(e.data));
          tests = tests + 1;
          if ((cyc - e.t0) < LAT - 1 || (cyc - e.t0) > LAT + 1) begin
            fails = fails + 1;
            $display("FAIL latency: got %0d, expected %0d+/-1", cyc - e.t0, LAT);
          end
          last_good = e.data;
        end else if (o_frame_error) begin
          check("data_held_on_error", int'(o_data), int'(last_good));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural 8N1 transmitter; stop_low_len>0 forces a low stop bit held that long.
  task automatic send_frame(input logic [7:0] d, input int stop_low_len, input bit expect_pulse);
    exp_t e;
    e.is_err = (stop_low_len > 0);
    e.data   = d;
    e.t0     = cyc + 1;
    if (expect_pulse) exp_q.push_back(e);
    i_rx = 1'b0;
    wait_cyc(CPB);
    for (int b = 0; b < NB; b++) begin
      i_rx = d[b];
      wait_cyc(CPB);
    end
    if (stop_low_len > 0) begin
      i_rx = 1'b0;
      wait_cyc(stop_low_len);
    end else begin
      i_rx = 1'b1;
      wait_cyc(CPB);
    end
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] d;
    i_rx    = 1'b1;
    i_reset = 1'b1;
    wait_cyc(3);
    check("reset_o_data", int'(o_data), 0);
    check("reset_o_data_valid", int'(o_data_valid), 0);
    check("reset_o_frame_error", int'(o_frame_error), 0);
    check("reset_o_busy", int'(o_busy), 0);
    i_reset = 1'b0;
    wait_cyc(5);

    send_frame(8'hA5, 0, 1'b1);
    wait_cyc(4);

    // Short low glitch on an idle line must be rejected.
    i_rx = 1'b0;
    wait_cyc(5);
    i_rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_busy) busy_cnt++;
      wait_cyc(1);
    end
    busy_cnt = busy_cnt + 4;
    tests = tests + 1;
    if (busy_cnt < 6 || busy_cnt > 10) begin
      fails = fails + 1;
      $display("FAIL glitch_busy_len: got %0d, expected about 8", busy_cnt);
    end
    check("glitch_busy_cleared", int'(o_busy), 0);
    check("glitch_data_held", int'(o_data), int'(last_good));

    // Framing error followed by a held-low break.
    send_frame(8'h3C, CPB + 40, 1'b1);
    check("break_busy_held", int'(o_busy), 1);
    i_rx = 1'b1;
    wait_cyc(5);
    check("break_busy_released", int'(o_busy), 0);
    check("break_data_held", int'(o_data), int'(last_good));
    wait_cyc(3);

    send_frame(8'h00, 0, 1'b1);
    send_frame(8'hFF, 0, 1'b1);
    wait_cyc(6);

    // Reset in the middle of data bit 4 of a frame.
    i_rx = 1'b0;
    wait_cyc(CPB);
    for (int b = 0; b < 4; b++) wait_cyc(CPB);
    wait_cyc(CPB / 2);
    i_reset = 1'b1;
    i_rx    = 1'b1;
    wait_cyc(1);
    i_reset = 1'b0;
    last_good = 8'h00;
    check("midreset_o_data", int'(o_data), 0);
    check("midreset_o_valid", int'(o_data_valid), 0);
    check("midreset_o_error", int'(o_frame_error), 0);
    check("midreset_o_busy", int'(o_busy), 0);
    wait_cyc(CPB * 12);
    send_frame(8'h81, 0, 1'b1);
    wait_cyc(3);

    send_frame(8'b10101010, 0, 1'b1);
    wait_cyc(3);

    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 0, 1'b1);
      wait_cyc($urandom_range(0, 20));
    end

    for (int t = 0; t < 400 && exp_q.size() != 0; t++) wait_cyc(1);
    check("scoreboard_drained", exp_q.size(), 0);
    wait_cyc(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
